// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the datapath blocks.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
   parameter int CNT_W = 16
) ();

   logic             start;
   logic [31:0]      instruction;
   logic [7:0]       program_counter;
   logic             alu_zero;
   logic             mem_ready;

   logic [2:0]       state;
   logic             reg_write;
   logic             link_write;
   logic             mem_read;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             halted;
   logic             illegal;
   logic             mem_timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] retired_count;

   modport master (
      input  start,
      input  instruction,
      input  program_counter,
      input  alu_zero,
      input  mem_ready,
      output state,
      output reg_write,
      output link_write,
      output mem_read,
      output pc_write,
      output pc_src,
      output halted,
      output illegal,
      output mem_timeout,
      output cycle_count,
      output retired_count
   );

   modport slave (
      output start,
      output instruction,
      output program_counter,
      output alu_zero,
      output mem_ready,
      input  state,
      input  reg_write,
      input  link_write,
      input  mem_read,
      input  pc_write,
      input  pc_src,
      input  halted,
      input  illegal,
      input  mem_timeout,
      input  cycle_count,
      input  retired_count
   );

endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS-subset core: phase sequencing,
// per-phase strobes, halt detection and performance counters.
module multicycle_controller #(
   parameter int IMEM_DEPTH  = 14,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input logic                     clk,
   input logic                     rst,
   multicycle_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_IDLE = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_NONE  = 3'd0,
      C_ARITH = 3'd1,
      C_LOAD  = 3'd2,
      C_BEQ   = 3'd3,
      C_BNE   = 3'd4,
      C_JAL   = 3'd5,
      C_JR    = 3'd6
   } class_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LOAD  = 6'h17;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   localparam logic [1:0] PC_REG = 2'b11;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [7:0] PC_LIMIT = 8'(IMEM_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q;
   state_t            state_d;
   class_t            class_q;
   class_t            class_d;
   class_t            dec_class;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              illegal_q;
   logic              illegal_d;
   logic              mto_q;
   logic              mto_d;
   logic [CNT_W-1:0]  cyc_q;
   logic [CNT_W-1:0]  ret_q;
   logic              active;
   logic              retire;

   logic [5:0] opcode;
   logic [5:0] funct;

   assign opcode = bus.instruction[31:26];
   assign funct  = bus.instruction[5:0];

   always_comb begin
      dec_class = C_NONE;
      unique case (1'b1)
         (opcode == OP_RTYPE) && (funct == FN_ADDU): dec_class = C_ARITH;
         (opcode == OP_RTYPE) && (funct == FN_SLT):  dec_class = C_ARITH;
         (opcode == OP_RTYPE) && (funct == FN_JR):   dec_class = C_JR;
         opcode == OP_ADDIU:                         dec_class = C_ARITH;
         opcode == OP_LOAD:                          dec_class = C_LOAD;
         opcode == OP_BEQ:                           dec_class = C_BEQ;
         opcode == OP_BNE:                           dec_class = C_BNE;
         opcode == OP_JAL:                           dec_class = C_JAL;
         default:                                    dec_class = C_NONE;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      wait_d    = wait_q;
      illegal_d = illegal_q;
      mto_d     = mto_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_IF;
         end
         S_IF: begin
            if (bus.program_counter >= PC_LIMIT) state_d = S_HALT;
            else                                 state_d = S_ID;
         end
         S_ID: begin
            if (dec_class == C_NONE) begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end else begin
               state_d = S_EX;
               class_d = dec_class;
            end
         end
         S_EX: begin
            case (class_q)
               C_LOAD: begin
                  state_d = S_MEM;
                  wait_d  = '0;
               end
               C_ARITH, C_JAL: state_d = S_WB;
               default:        state_d = S_IF;
            endcase
         end
         // ready on the final wait cycle still completes the load
         S_MEM: begin
            if (bus.mem_ready) begin
               state_d = S_WB;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_HALT;
               mto_d   = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB:    state_d = S_IF;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   assign active = (state_q == S_IF) || (state_q == S_ID) ||
                   (state_q == S_EX) || (state_q == S_MEM) ||
                   (state_q == S_WB);

   assign retire = (state_q == S_WB) ||
                   ((state_q == S_EX) &&
                    ((class_q == C_BEQ) || (class_q == C_BNE) ||
                     (class_q == C_JR)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         class_q   <= C_NONE;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         mto_q     <= 1'b0;
         cyc_q     <= '0;
         ret_q     <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         mto_q     <= mto_d;
         if (active && (cyc_q != CNT_MAX)) cyc_q <= cyc_q + 1'b1;
         if (retire && (ret_q != CNT_MAX)) ret_q <= ret_q + 1'b1;
      end
   end

   logic       reg_write;
   logic       link_write;
   logic       mem_read;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       halted;

   always_comb begin
      reg_write  = 1'b0;
      link_write = 1'b0;
      mem_read   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SEQ;
      halted     = 1'b0;
      case (state_q)
         S_EX: begin
            case (class_q)
               C_BEQ: begin
                  pc_write = bus.alu_zero;
                  pc_src   = PC_BR;
               end
               C_BNE: begin
                  pc_write = !bus.alu_zero;
                  pc_src   = PC_BR;
               end
               C_JR: begin
                  pc_write = 1'b1;
                  pc_src   = PC_REG;
               end
               C_JAL: begin
                  pc_write = 1'b1;
                  pc_src   = PC_JMP;
               end
               default: ;
            endcase
         end
         S_MEM: mem_read = 1'b1;
         S_WB: begin
            reg_write  = (class_q == C_ARITH) || (class_q == C_LOAD);
            link_write = (class_q == C_JAL);
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.state         = state_q;
   assign bus.reg_write     = reg_write;
   assign bus.link_write    = link_write;
   assign bus.mem_read      = mem_read;
   assign bus.pc_write      = pc_write;
   assign bus.pc_src        = pc_src;
   assign bus.halted        = halted;
   assign bus.illegal       = illegal_q;
   assign bus.mem_timeout   = mto_q;
   assign bus.cycle_count   = cyc_q;
   assign bus.retired_count = ret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Vector-table bench for multicycle_controller; expected outputs go through
// a scoreboard queue and are compared one edge after being driven.
module tb_multicycle_controller;

   localparam logic [31:0] I_ADDIU = 32'h24020000;
   localparam logic [31:0] I_LW    = 32'h5C01000A;
   localparam logic [31:0] I_BEQ   = 32'h10800000;
   localparam logic [31:0] I_BNE   = 32'h14800000;
   localparam logic [31:0] I_JR    = 32'h03E00008;
   localparam logic [31:0] I_JAL   = 32'h0C000000;
   localparam logic [31:0] I_ADDU  = 32'h00221821;
   localparam logic [31:0] I_SLT   = 32'h0022182A;
   localparam logic [31:0] I_BAD   = 32'hFC000000;
   localparam logic [31:0] I_ADD   = 32'h00221820;

   localparam logic [2:0] ST_IF   = 3'd0;
   localparam logic [2:0] ST_ID   = 3'd1;
   localparam logic [2:0] ST_EX   = 3'd2;
   localparam logic [2:0] ST_MEM  = 3'd3;
   localparam logic [2:0] ST_WB   = 3'd4;
   localparam logic [2:0] ST_HALT = 3'd5;
   localparam logic [2:0] ST_IDLE = 3'd6;

   // {rw, lk, mrd, pw, ps[1:0], h, il, mt}
   localparam logic [8:0] F_RW  = 9'h100;
   localparam logic [8:0] F_LK  = 9'h080;
   localparam logic [8:0] F_MR  = 9'h040;
   localparam logic [8:0] F_PW  = 9'h020;
   localparam logic [8:0] F_PS1 = 9'h008;
   localparam logic [8:0] F_PS2 = 9'h010;
   localparam logic [8:0] F_PS3 = 9'h018;
   localparam logic [8:0] F_H   = 9'h004;
   localparam logic [8:0] F_IL  = 9'h002;
   localparam logic [8:0] F_MT  = 9'h001;

   typedef struct packed {
      logic [2:0]  st;
      logic        rw;
      logic        lk;
      logic        mrd;
      logic        pw;
      logic [1:0]  ps;
      logic        h;
      logic        il;
      logic        mt;
      logic [15:0] cyc;
      logic [15:0] ret;
   } out_t;

   typedef struct {
      logic        rst;
      logic        start;
      logic [31:0] ins;
      logic [7:0]  pc;
      logic        az;
      logic        mr;
      out_t        exp;
   } vec_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   vec_t vecs[$];
   out_t sb[$];

   multicycle_controller_if #(.CNT_W(16)) bus ();

   multicycle_controller #(
      .IMEM_DEPTH(14),
      .MEM_TIMEOUT(15),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic        r,
      input logic        s,
      input logic [31:0] ins,
      input logic [7:0]  pc,
      input logic        az,
      input logic        mr,
      input logic [2:0]  st,
      input logic [8:0]  fl,
      input int          cyc,
      input int          ret
   );
      vec_t v;
      v.rst       = r;
      v.start     = s;
      v.ins       = ins;
      v.pc        = pc;
      v.az        = az;
      v.mr        = mr;
      v.exp.st    = st;
      v.exp.rw    = fl[8];
      v.exp.lk    = fl[7];
      v.exp.mrd   = fl[6];
      v.exp.pw    = fl[5];
      v.exp.ps    = fl[4:3];
      v.exp.h     = fl[2];
      v.exp.il    = fl[1];
      v.exp.mt    = fl[0];
      v.exp.cyc   = 16'(cyc);
      v.exp.ret   = 16'(ret);
      return v;
   endfunction

   task automatic t_rst();
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0));
   endtask

   task automatic t_go();
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, ST_IF, 0, 0, 0));
   endtask

   task automatic t_s(
      input logic        s,
      input logic [31:0] ins,
      input logic [7:0]  pc,
      input logic        az,
      input logic        mr,
      input logic [2:0]  st,
      input logic [8:0]  fl,
      input int          cyc,
      input int          ret
   );
      vecs.push_back(mk(0, s, ins, pc, az, mr, st, fl, cyc, ret));
   endtask

   // branch / jr: ID -> EX -> IF, retires on leaving EX
   task automatic t_br(
      input logic [31:0] ins,
      input logic        az,
      input logic [8:0]  fl_ex,
      input int          c,
      input int          r
   );
      t_s(0, ins, 2, 0, 0, ST_ID, 0, c, r);
      t_s(0, ins, 2, az, 0, ST_EX, fl_ex, c + 1, r);
      t_s(0, ins, 2, 0, 0, ST_IF, 0, c + 2, r + 1);
   endtask

   // arith / jal: ID -> EX -> WB -> IF
   task automatic t_wb(
      input logic [31:0] ins,
      input logic [8:0]  fl_ex,
      input logic [8:0]  fl_wb,
      input int          c,
      input int          r
   );
      t_s(0, ins, 2, 0, 0, ST_ID, 0, c, r);
      t_s(0, ins, 2, 0, 0, ST_EX, fl_ex, c + 1, r);
      t_s(0, ins, 2, 0, 0, ST_WB, fl_wb, c + 2, r);
      t_s(0, ins, 2, 0, 0, ST_IF, 0, c + 3, r + 1);
   endtask

   // load with nw extra not-ready MEM cycles, then ready
   task automatic t_load(input int c, input int r, input int nw);
      t_s(0, I_LW, 1, 0, 0, ST_ID, 0, c, r);
      t_s(0, I_LW, 1, 0, 0, ST_EX, 0, c + 1, r);
      t_s(0, I_LW, 1, 0, 0, ST_MEM, F_MR, c + 2, r);
      for (int k = 0; k < nw; k++)
         t_s(0, I_LW, 1, 0, 0, ST_MEM, F_MR, c + 3 + k, r);
      t_s(0, I_LW, 1, 0, 1, ST_WB, F_RW, c + 3 + nw, r);
      t_s(0, I_LW, 1, 0, 0, ST_IF, 0, c + 4 + nw, r + 1);
   endtask

   task automatic run_vecs();
      out_t exp;
      out_t act;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst                 = vecs[i].rst;
         bus.start           = vecs[i].start;
         bus.instruction     = vecs[i].ins;
         bus.program_counter = vecs[i].pc;
         bus.alu_zero        = vecs[i].az;
         bus.mem_ready       = vecs[i].mr;
         sb.push_back(vecs[i].exp);
         @(posedge clk);
         #1;
         exp = sb.pop_front();
         act.st  = bus.state;
         act.rw  = bus.reg_write;
         act.lk  = bus.link_write;
         act.mrd = bus.mem_read;
         act.pw  = bus.pc_write;
         act.ps  = bus.pc_src;
         act.h   = bus.halted;
         act.il  = bus.illegal;
         act.mt  = bus.mem_timeout;
         act.cyc = bus.cycle_count;
         act.ret = bus.retired_count;
         n_chk++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d got st=%0d fl=%b cyc=%0d ret=%0d want st=%0d fl=%b cyc=%0d ret=%0d",
                     i, act.st, act[34:32], act.cyc, act.ret,
                     exp.st, exp[34:32], exp.cyc, exp.ret);
            $display("  vec%0d strobes got %b want %b", i, act[40:32], exp[40:32]);
         end
      end
      vecs.delete();
   endtask

   initial begin
      clk                 = 1'b0;
      rst                 = 1'b1;
      n_chk               = 0;
      n_fail              = 0;
      bus.start           = 1'b0;
      bus.instruction     = '0;
      bus.program_counter = '0;
      bus.alu_zero        = 1'b0;
      bus.mem_ready       = 1'b0;

      // addiu at the last legal PC; start pulse in ID is ignored
      t_rst();
      t_s(0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0);
      t_go();
      t_s(0, I_ADDIU, 13, 0, 0, ST_ID, 0, 1, 0);
      t_s(1, I_ADDIU, 13, 0, 0, ST_EX, 0, 2, 0);
      t_s(0, I_ADDIU, 13, 0, 0, ST_WB, F_RW, 3, 0);
      t_s(0, I_ADDIU, 13, 0, 0, ST_IF, 0, 4, 1);

      // lw with three wait cycles, then every control-flow class
      t_rst();
      t_go();
      t_load(1, 0, 3);
      t_br(I_BEQ, 1, F_PW | F_PS1, 9, 1);
      t_br(I_BEQ, 0, F_PS1, 12, 2);
      t_br(I_BNE, 1, F_PS1, 15, 3);
      t_br(I_BNE, 0, F_PW | F_PS1, 18, 4);
      t_br(I_JR, 0, F_PW | F_PS3, 21, 5);
      t_wb(I_JAL, F_PW | F_PS2, F_LK, 24, 6);
      t_wb(I_ADDU, 0, F_RW, 28, 7);
      t_wb(I_SLT, 0, F_RW, 32, 8);
      t_s(0, I_BAD, 2, 0, 0, ST_ID, 0, 36, 9);
      t_s(0, I_BAD, 2, 0, 0, ST_HALT, F_H | F_IL, 37, 9);
      t_s(1, I_BAD, 2, 0, 0, ST_HALT, F_H | F_IL, 37, 9);
      t_s(1, I_BAD, 2, 0, 0, ST_HALT, F_H | F_IL, 37, 9);

      // fetch past end of instruction memory
      t_rst();
      t_go();
      t_s(0, I_ADDIU, 14, 0, 0, ST_HALT, F_H, 1, 0);
      t_s(1, I_ADDIU, 14, 0, 0, ST_HALT, F_H, 1, 0);

      // unsupported R-type funct
      t_rst();
      t_go();
      t_s(0, I_ADD, 3, 0, 0, ST_ID, 0, 1, 0);
      t_s(0, I_ADD, 3, 0, 0, ST_HALT, F_H | F_IL, 2, 0);
      run_vecs();

      // load never ready: 15 MEM cycles then timeout halt
      t_rst();
      t_go();
      t_s(0, I_LW, 1, 0, 0, ST_ID, 0, 1, 0);
      t_s(0, I_LW, 1, 0, 0, ST_EX, 0, 2, 0);
      t_s(0, I_LW, 1, 0, 0, ST_MEM, F_MR, 3, 0);
      for (int k = 0; k < 14; k++)
         t_s(0, I_LW, 1, 0, 0, ST_MEM, F_MR, 4 + k, 0);
      t_s(0, I_LW, 1, 0, 0, ST_HALT, F_H | F_MT, 18, 0);
      t_s(1, I_LW, 1, 0, 0, ST_HALT, F_H | F_MT, 18, 0);

      // ready on the timeout cycle wins; wait count restarts per load
      t_rst();
      t_go();
      t_load(1, 0, 14);
      t_load(20, 1, 14);

      // reset in the middle of a MEM wait
      t_rst();
      t_go();
      t_s(0, I_LW, 1, 0, 0, ST_ID, 0, 1, 0);
      t_s(0, I_LW, 1, 0, 0, ST_EX, 0, 2, 0);
      t_s(0, I_LW, 1, 0, 0, ST_MEM, F_MR, 3, 0);
      t_s(0, I_LW, 1, 0, 0, ST_MEM, F_MR, 4, 0);
      t_rst();
      t_go();
      run_vecs();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
